// File: rtl/fc_layer_sequencer.sv
// Serial-in / serial-out control and data sequencer for one fully-connected layer of fc_neurons.
// Define FC_SEQ_RELU_EN to clamp negative neuron outputs to zero when they are captured.
module fc_layer_sequencer #(
  parameter int WORD_SIZE             = 16,
  parameter int PREVIOUS_LAYER_HEIGHT = 4,
  parameter int LAYER_HEIGHT          = 2,
  parameter int LU_LATENCY            = 1,
  localparam int ADDR_W               = $clog2(PREVIOUS_LAYER_HEIGHT + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 valid_i,
  output logic                                 ready_o,
  input  logic signed [WORD_SIZE-1:0]          data_i,
  output logic        [ADDR_W-1:0]             mem_addr_o,
  output logic signed [WORD_SIZE-1:0]          neuron_data_o,
  output logic                                 sum_en_o,
  output logic                                 add_bias_o,
  input  logic [WORD_SIZE*LAYER_HEIGHT-1:0]    neuron_data_i,
  output logic                                 valid_o,
  input  logic                                 ready_i,
  output logic signed [WORD_SIZE-1:0]          data_o
);

  localparam int IDX_W = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;
  localparam int CNT_W = $clog2(LU_LATENCY + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PREVIOUS_LAYER_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] BIAS_ADDR = ADDR_W'(PREVIOUS_LAYER_HEIGHT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(LAYER_HEIGHT - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LU_LATENCY);

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_BIAS,
    ST_WAIT,
    ST_DRAIN
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic signed [WORD_SIZE-1:0] ndata_q, ndata_d;
  logic                        sum_en_q, sum_en_d;
  logic                        add_bias_q, add_bias_d;
  logic                        ready_q, ready_d;
  logic                        valid_q, valid_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic signed [WORD_SIZE-1:0] buf_q [LAYER_HEIGHT];
  logic signed [WORD_SIZE-1:0] buf_d [LAYER_HEIGHT];
  logic signed [WORD_SIZE-1:0] lane_word [LAYER_HEIGHT];
  logic                        accept;

  function automatic logic signed [WORD_SIZE-1:0] capture_word(input logic signed [WORD_SIZE-1:0] w);
`ifdef FC_SEQ_RELU_EN
    return w[WORD_SIZE-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < LAYER_HEIGHT; gi++) begin : g_lane
      assign lane_word[gi] = capture_word(neuron_data_i[gi*WORD_SIZE +: WORD_SIZE]);
    end
  endgenerate

  // ready_q is only ever high in ACCUM, so it doubles as the accept qualifier.
  assign accept = valid_i && ready_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    ndata_d    = ndata_q;
    sum_en_d   = 1'b0;
    add_bias_d = 1'b0;
    ready_d    = ready_q;
    valid_d    = valid_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;

    case (state_q)
      ST_ACCUM: begin
        ready_d = 1'b1;
        if (accept) begin
          ndata_d  = data_i;
          sum_en_d = 1'b1;
          if (addr_q == LAST_ADDR) begin
            addr_d  = BIAS_ADDR;
            ready_d = 1'b0;
            state_d = ST_BIAS;
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      ST_BIAS: begin
        add_bias_d = 1'b1;
        addr_d     = '0;
        cnt_d      = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        // cnt_q is 0 during the add_bias cycle, so LAST_CNT lands LU_LATENCY cycles later.
        if (cnt_q == LAST_CNT) begin
          for (int n = 0; n < LAYER_HEIGHT; n++) begin
            buf_d[n] = lane_word[n];
          end
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (valid_q && ready_i) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            idx_d   = '0;
            ready_d = 1'b1;
            state_d = ST_ACCUM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= ST_ACCUM;
      addr_q     <= '0;
      ndata_q    <= '0;
      sum_en_q   <= 1'b0;
      add_bias_q <= 1'b0;
      ready_q    <= 1'b0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      cnt_q      <= '0;
      for (int n = 0; n < LAYER_HEIGHT; n++) begin
        buf_q[n] <= '0;
      end
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      ndata_q    <= ndata_d;
      sum_en_q   <= sum_en_d;
      add_bias_q <= add_bias_d;
      ready_q    <= ready_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
    end
  end

  assign ready_o       = ready_q;
  assign mem_addr_o    = addr_q;
  assign neuron_data_o = ndata_q;
  assign sum_en_o      = sum_en_q;
  assign add_bias_o    = add_bias_q;
  assign valid_o       = valid_q;
  assign data_o        = buf_q[idx_q];

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer: directed vectors plus randomized vectors with
// bubbles and back-pressure, checked cycle by cycle against the expected sequencing timeline.
module tb_fc_layer_sequencer;

  localparam int W  = 16;
  localparam int H  = 4;
  localparam int N  = 2;
  localparam int L  = 1;
  localparam int AW = $clog2(H + 1);

  logic                clk_i;
  logic                reset_i;
  logic                valid_i;
  logic                ready_o;
  logic signed [W-1:0] data_i;
  logic [AW-1:0]       mem_addr_o;
  logic signed [W-1:0] neuron_data_o;
  logic                sum_en_o;
  logic                add_bias_o;
  logic [W*N-1:0]      neuron_data_i;
  logic                valid_o;
  logic                ready_i;
  logic signed [W-1:0] data_o;

  fc_layer_sequencer #(
    .WORD_SIZE(W),
    .PREVIOUS_LAYER_HEIGHT(H),
    .LAYER_HEIGHT(N),
    .LU_LATENCY(L)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i(data_i),
    .mem_addr_o(mem_addr_o),
    .neuron_data_o(neuron_data_o),
    .sum_en_o(sum_en_o),
    .add_bias_o(add_bias_o),
    .neuron_data_i(neuron_data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o(data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int vec_no = 0;

  bit             vpat[$];
  bit             rpat[$];
  logic [W-1:0]   words_g[H];
  logic [W-1:0]   outs_g[N];
  logic [W-1:0]   last_word;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [W-1:0] exp_out(input logic [W-1:0] w);
`ifdef FC_SEQ_RELU_EN
    return w[W-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [W*N-1:0] pack_outs();
    logic [W*N-1:0] p;
    for (int n = 0; n < N; n++) p[n*W +: W] = outs_g[n];
    return p;
  endfunction

  task automatic random_words();
    for (int i = 0; i < H; i++) words_g[i] = W'($urandom);
    for (int n = 0; n < N; n++) outs_g[n] = W'($urandom);
  endtask

  task automatic run_vector(input bit abort_in_wait);
    int  k;
    int  guard;
    bit  acc_prev;
    bit  v;
    bit  r;
    k = 0;
    guard = 0;
    acc_prev = 1'b0;
    // accumulation: one sum_en cycle after every accept, address = next expected word
    while (k < H) begin
      chk("accum_ready", W'(ready_o), W'(1));
      chk("accum_addr", W'(mem_addr_o), W'(k));
      chk("accum_sum_en", W'(sum_en_o), W'(acc_prev));
      chk("accum_ndata", neuron_data_o, last_word);
      chk("accum_add_bias", W'(add_bias_o), W'(0));
      chk("accum_valid_o", W'(valid_o), W'(0));
      if (vpat.size() > 0) v = vpat.pop_front();
      else v = ($urandom_range(99) >= 30) || (guard > 50);
      valid_i = v;
      data_i  = v ? words_g[k] : W'($urandom);
      acc_prev = v;
      if (v) begin
        last_word = words_g[k];
        k++;
      end
      guard++;
      step();
    end
    // bias-address cycle carrying the final sum_en
    chk("bias_ready", W'(ready_o), W'(0));
    chk("bias_addr", W'(mem_addr_o), W'(H));
    chk("bias_sum_en", W'(sum_en_o), W'(1));
    chk("bias_ndata", neuron_data_o, last_word);
    chk("bias_add_bias", W'(add_bias_o), W'(0));
    valid_i = 1'($urandom_range(1));
    data_i  = W'($urandom);
    step();
    // add_bias cycle, then LU_LATENCY wait cycles; real outputs only on the capture cycle
    for (int j = 0; j <= L; j++) begin
      chk("wait_add_bias", W'(add_bias_o), W'(j == 0));
      chk("wait_sum_en", W'(sum_en_o), W'(0));
      chk("wait_ready", W'(ready_o), W'(0));
      chk("wait_addr", W'(mem_addr_o), W'(0));
      chk("wait_valid_o", W'(valid_o), W'(0));
      neuron_data_i = (j == L) ? pack_outs() : {N{W'($urandom)}};
      valid_i = 1'($urandom_range(1));
      if (abort_in_wait && j == 0) begin
        reset_i = 1'b0;
        valid_i = 1'b0;
        step();
        reset_i = 1'b1;
        last_word = '0;
        chk("abort_ready", W'(ready_o), W'(0));
        chk("abort_valid_o", W'(valid_o), W'(0));
        chk("abort_add_bias", W'(add_bias_o), W'(0));
        chk("abort_ndata", neuron_data_o, W'(0));
        step();
        chk("abort_ready_rise", W'(ready_o), W'(1));
        chk("abort_valid_o_low", W'(valid_o), W'(0));
        chk("abort_addr", W'(mem_addr_o), W'(0));
        $display("vector %0d aborted by reset in WAIT", vec_no);
        vec_no++;
        return;
      end
      step();
    end
    neuron_data_i = {N{W'($urandom)}};
    // drain in neuron order, data_o stable while stalled
    for (int i = 0; i < N; i++) begin
      guard = 0;
      do begin
        chk("drain_valid_o", W'(valid_o), W'(1));
        chk("drain_data_o", data_o, exp_out(outs_g[i]));
        chk("drain_ready", W'(ready_o), W'(0));
        chk("drain_sum_en", W'(sum_en_o), W'(0));
        if (rpat.size() > 0) r = rpat.pop_front();
        else r = ($urandom_range(99) >= 40) || (guard > 50);
        ready_i = r;
        valid_i = 1'($urandom_range(1));
        guard++;
        step();
      end while (!r);
    end
    ready_i = 1'b0;
    valid_i = 1'b0;
    chk("post_valid_o", W'(valid_o), W'(0));
    chk("post_ready", W'(ready_o), W'(1));
    chk("post_addr", W'(mem_addr_o), W'(0));
    $display("vector %0d done: out0=%h out%0d=%h", vec_no, exp_out(outs_g[0]), N-1, exp_out(outs_g[N-1]));
    vec_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    reset_i = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b0;
    data_i  = 16'sh1234;
    neuron_data_i = '0;
    last_word = '0;

    // reset held three cycles with valid_i high
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst_ready", W'(ready_o), W'(0));
      chk("rst_addr", W'(mem_addr_o), W'(0));
      chk("rst_ndata", neuron_data_o, W'(0));
      chk("rst_sum_en", W'(sum_en_o), W'(0));
      chk("rst_add_bias", W'(add_bias_o), W'(0));
      chk("rst_valid_o", W'(valid_o), W'(0));
      chk("rst_data_o", data_o, W'(0));
    end
    reset_i = 1'b1;
    valid_i = 1'b0;
    step();
    chk("rel_ready", W'(ready_o), W'(1));
    chk("rel_addr", W'(mem_addr_o), W'(0));

    // continuous 1,2,3,4
    random_words();
    for (int i = 0; i < H; i++) words_g[i] = W'(i + 1);
    for (int i = 0; i < H; i++) vpat.push_back(1'b1);
    run_vector(1'b0);

    // bubbles plus stalled drain with a negative neuron output
    random_words();
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    outs_g[0] = 16'hFFFD;
    outs_g[1] = 16'h0005;
    rpat = '{1'b0, 1'b0, 1'b1, 1'b1};
    run_vector(1'b0);

    // reset during WAIT, then a clean vector from address 0
    random_words();
    run_vector(1'b1);
    random_words();
    for (int i = 0; i < H; i++) vpat.push_back(1'b1);
    run_vector(1'b0);

    for (int t = 0; t < 25; t++) begin
      random_words();
      run_vector(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
